calc_arb: RTL and testbench
===========================

// Module: calc_arb
// PURPOSE
// - Shares one calc datapath (A,B,C -> Z polynomial engine) among NREQ requesters.
// - Round-robin picks one requester per cycle and pushes its A,B,C triplet into calc in one cycle.
// - Tags each issue with the requester index and returns each calc result on one tagged output stream.
// - A credit scheme guarantees that no calc result is lost, because calc itself cannot be stalled.
// PARAMETERS
// - NREQ   4   number of requesters (2..16)
// - DEPTH  4   result-buffer entries; also the maximum in-flight plus buffered results
// - TAGW   2   tag width, = clog2(NREQ); supplied from calc_arb_pkg
// PORTS
// - clk       in   1        single clock; all state changes on posedge clk
// - rst_n     in   1        asynchronous, active-low reset
// - req_push  in   NREQ     requester i holds a valid triplet
// - req_stop  out  NREQ     combinational; 0 only for the requester granted this cycle
// - req_A     in   NREQ*32  packed operands; requester i uses bits [32i+31:32i]
// - req_B     in   NREQ*32  as req_A
// - req_C     in   NREQ*32  as req_A
// - c_A,c_B,c_C          out 32 each  operands driven to calc
// - c_pushA,c_pushB,c_pushC out 1 each always asserted together
// - c_stopA,c_stopB,c_stopC in  1 each stop inputs from calc
// - c_Z       in   32       result from calc
// - c_pushZ   in   1        calc result valid; may not be back-pressured
// - Z         out  32       result at the head of the result buffer
// - tagZ      out  TAGW     requester index for Z
// - pushZ     out  1        result buffer is not empty
// - stopZ     in   1        downstream stall
// - err       out  1        sticky: c_pushZ arrived with no tag outstanding
// BEHAVIOUR
// - Reset values: req_stop=all 1, c_push*=0, c_A/B/C=0, Z=0, tagZ=0, pushZ=0, err=0.
//   Reset clears the RR pointer, both FIFOs and the credit count.
// - Issue condition, evaluated each cycle:
//   - any req_push is 1;
//   - c_stopA, c_stopB and c_stopC are all 0;
//   - credit is available: tag_fifo count + result count < DEPTH.
// - Grant: the first i with req_push[i]=1, searching from (last_grant+1) mod NREQ upward with wrap.
//   last_grant updates only on an issue.
// - On issue to requester g:
//   - req_stop[g]=0;
//   - c_push*=1 with c_A/B/C = req_A/B/C[g], combinational in the same cycle;
//   - g is pushed into tag_fifo.
//   - Transfer happens when req_push[g]=1 and req_stop[g]=0.
//   - A requester keeps push and data stable until it is accepted.
// - No issue: all req_stop=1 and c_push*=0.
// - c_pushZ=1:
//   - pop the tag_fifo head;
//   - write {tag, c_Z} into the result FIFO at this posedge.
//   - If tag_fifo is empty: set err, discard the result, leave state unchanged.
// - Output: pushZ=!empty; Z/tagZ = head entry. An entry pops when pushZ=1 and stopZ=0.
// - Minimum latency is 3 cycles from an accepted request to pushZ:
//   - calc returns its result 2 cycles after issue;
//   - 1 more cycle for the result-buffer write.
// - Throughput: 1 issue per cycle while credit remains and stopZ=0.
// - Boundaries:
//   - Credits exhausted: no grant (all req_stop=1), even if calc is idle.
//   - Issue, c_pushZ and output pop in the same cycle are all legal.
//     Counts update as +1 (issue), +1-1 (c_pushZ transfer) and -1 (pop).
//   - The result FIFO can never overflow, because credit accounting forbids it.
//   - Wrap: the RR search past NREQ-1 wraps to 0.
//   - A requester that drops push before it is granted is legal; it is simply skipped.
// - rst_n asserted mid-operation discards all in-flight results.
//   - calc must be reset by the same event (rst = !rst_n).
// - Z holds calc's 32-bit value unmodified; any modulo 2^32 wrap is done inside calc.
// STRUCTURE
// - calc_arb_pkg holds:
//   - CALC_W=32;
//   - CALC_LAT=2, used by the testbench only;
//   - function clog2 for TAGW;
//   - the typedef of the result entry {tag, Z}.
// - Sub-module calc_arb_fifo: a parameterised synchronous FIFO (width, depth, count output).
//   - Instance 1: tag_fifo, width TAGW.
//   - Instance 2: result FIFO, width TAGW+32.
// - The top level contains the RR arbiter, credit compare, operand mux and err flag.
// TESTING
// - Single request: req0 A=B=C=1 -> 1 issue cycle; 3 cycles later pushZ=1, Z=7, tagZ=0.
// - All 4 requesting every cycle: grants occur in order 0,1,2,3,0; tags are returned in issue order.
//   - req1 A=2,B=0,C=0 -> Z=32; req2 B=2 -> Z=8; req3 C=3 -> Z=9.
// - stopZ=1 held: exactly DEPTH=4 issues, then all req_stop=1.
//   - Releasing stopZ for 1 pop allows exactly 1 more issue.
// - c_stopA forced to 1 by the calc model -> no c_push* while it is high; the pending requester stays stopped.
// - Injected c_pushZ with no issue outstanding -> err=1 and stays 1; pushZ stays 0.
// - rst_n pulsed low with 3 results in flight -> all outputs return to reset values.
//   - After release, the first result is from a new request only.

Source files
------------

// File: rtl/calc_arb_pkg.sv
// Shared constants, the tag-width helper and the result-entry layout for the calc arbiter.
package calc_arb_pkg;

    localparam int CALC_W   = 32;
    localparam int CALC_LAT = 2;
    localparam int NREQ_DEF = 4;

    // Never returns less than 1 so that a 2-entry structure still gets a real pointer bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int TAGW_DEF = clog2(NREQ_DEF);

    typedef struct packed {
        logic [TAGW_DEF-1:0] tag;
        logic [CALC_W-1:0]   z;
    } res_entry_t;

endpackage

// File: rtl/calc_arb_if.sv
// Requester, calc and result-stream signals of the arbiter; slave = arbiter view, master = environment view.
interface calc_arb_if
    import calc_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = clog2(NREQ)
) ();

    logic [NREQ-1:0]        req_push;
    logic [NREQ-1:0]        req_stop;
    logic [NREQ*CALC_W-1:0] req_A;
    logic [NREQ*CALC_W-1:0] req_B;
    logic [NREQ*CALC_W-1:0] req_C;

    logic [CALC_W-1:0]      c_A;
    logic [CALC_W-1:0]      c_B;
    logic [CALC_W-1:0]      c_C;
    logic                   c_pushA;
    logic                   c_pushB;
    logic                   c_pushC;
    logic                   c_stopA;
    logic                   c_stopB;
    logic                   c_stopC;
    logic [CALC_W-1:0]      c_Z;
    logic                   c_pushZ;

    logic [CALC_W-1:0]      Z;
    logic [TAGW-1:0]        tagZ;
    logic                   pushZ;
    logic                   stopZ;
    logic                   err;

    modport slave (
        input  req_push, req_A, req_B, req_C,
        input  c_stopA, c_stopB, c_stopC, c_Z, c_pushZ,
        input  stopZ,
        output req_stop,
        output c_A, c_B, c_C, c_pushA, c_pushB, c_pushC,
        output Z, tagZ, pushZ, err
    );

    modport master (
        output req_push, req_A, req_B, req_C,
        output c_stopA, c_stopB, c_stopC, c_Z, c_pushZ,
        output stopZ,
        input  req_stop,
        input  c_A, c_B, c_C, c_pushA, c_pushB, c_pushC,
        input  Z, tagZ, pushZ, err
    );

endinterface

// File: rtl/calc_arb_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; pushes when full and pops when empty are ignored.
module calc_arb_fifo
    import calc_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         empty_o,
    output logic [clog2(DEPTH+1)-1:0]    count_o
);

    localparam int PTRW = clog2(DEPTH);
    localparam int CNTW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            wr_en;
    logic            rd_en;

    assign wr_en = push_i && (count_q != CNTW'(DEPTH));
    assign rd_en = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNTW'(wr_en) - CNTW'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/calc_arb.sv
// Round-robin sharing of one unstallable calc engine among NREQ requesters, with tagged,
// credit-protected result return.
module calc_arb
    import calc_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    calc_arb_if.slave bus
);

    localparam int TAGW = clog2(NREQ);
    localparam int CNTW = clog2(DEPTH + 1);
    localparam int ENTW = TAGW + CALC_W;

    logic [CALC_W-1:0] op_a [NREQ];
    logic [CALC_W-1:0] op_b [NREQ];
    logic [CALC_W-1:0] op_c [NREQ];

    logic [TAGW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAGW-1:0] grant;
    logic            grant_vld;
    logic            calc_ready;
    logic            credit_ok;
    logic            issue;

    logic [TAGW-1:0] tag_head;
    logic [CNTW-1:0] tag_cnt;
    logic            tag_empty;
    logic            tag_pop;

    logic [ENTW-1:0] res_head;
    logic [CNTW-1:0] res_cnt;
    logic            res_empty;
    logic            res_pop;
    logic [CNTW:0]   outstanding;

    logic            err_q, err_d;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ops
            assign op_a[gi] = bus.req_A[gi*CALC_W +: CALC_W];
            assign op_b[gi] = bus.req_B[gi*CALC_W +: CALC_W];
            assign op_c[gi] = bus.req_C[gi*CALC_W +: CALC_W];
        end
    endgenerate

    // First pending requester at or after rr_ptr_q, wrapping past NREQ-1.
    always_comb begin
        logic [TAGW:0]   sum;
        logic [TAGW-1:0] idx;
        sum       = '0;
        idx       = '0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (TAGW+1)'(k);
            if (sum >= (TAGW+1)'(NREQ)) begin
                sum = sum - (TAGW+1)'(NREQ);
            end
            idx = sum[TAGW-1:0];
            if (!grant_vld && bus.req_push[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    // Every slot is either a tag awaiting its result or a buffered result, so this bound
    // keeps the result FIFO from ever overflowing while calc cannot be stalled.
    assign outstanding = {1'b0, tag_cnt} + {1'b0, res_cnt};
    assign credit_ok   = outstanding < (CNTW+1)'(DEPTH);
    assign calc_ready  = !(bus.c_stopA || bus.c_stopB || bus.c_stopC);
    assign issue       = rst_n && grant_vld && calc_ready && credit_ok;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (grant == TAGW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_comb begin
        bus.req_stop = '1;
        bus.c_A      = '0;
        bus.c_B      = '0;
        bus.c_C      = '0;
        bus.c_pushA  = issue;
        bus.c_pushB  = issue;
        bus.c_pushC  = issue;
        if (issue) begin
            bus.req_stop[grant] = 1'b0;
            bus.c_A             = op_a[grant];
            bus.c_B             = op_b[grant];
            bus.c_C             = op_c[grant];
        end
    end

    assign tag_pop = bus.c_pushZ && !tag_empty;
    assign err_d   = err_q || (bus.c_pushZ && tag_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    calc_arb_fifo #(
        .WIDTH (TAGW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue),
        .data_i  (grant),
        .pop_i   (tag_pop),
        .data_o  (tag_head),
        .empty_o (tag_empty),
        .count_o (tag_cnt)
    );

    calc_arb_fifo #(
        .WIDTH (ENTW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tag_pop),
        .data_i  ({tag_head, bus.c_Z}),
        .pop_i   (res_pop),
        .data_o  (res_head),
        .empty_o (res_empty),
        .count_o (res_cnt)
    );

    assign res_pop   = !res_empty && !bus.stopZ;
    assign bus.pushZ = !res_empty;
    assign bus.Z     = res_empty ? '0 : res_head[CALC_W-1:0];
    assign bus.tagZ  = res_empty ? '0 : res_head[ENTW-1:CALC_W];
    assign bus.err   = err_q;

endmodule

// File: tb/tb_calc_arb.sv
// Directed bench for calc_arb with a two-stage calc model Z = A^5 + B^3 + C^2 + 4ABC (mod 2^32).
module tb_calc_arb;
    import calc_arb_pkg::*;

    logic clk;
    logic rst_n;
    logic stop_a;
    logic inj_pushZ;
    logic [CALC_W-1:0] inj_z;

    int n_vec;
    int n_err;

    calc_arb_if #(.NREQ(4)) bus ();

    calc_arb #(
        .NREQ  (4),
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CALC_W-1:0] calc_f(input logic [CALC_W-1:0] a,
                                                  input logic [CALC_W-1:0] b,
                                                  input logic [CALC_W-1:0] c);
        return a*a*a*a*a + b*b*b + c*c + 32'd4*a*b*c;
    endfunction

    logic              pv [CALC_LAT];
    logic [CALC_W-1:0] pz [CALC_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CALC_LAT; i++) begin
                pv[i] <= 1'b0;
                pz[i] <= '0;
            end
        end else begin
            pv[0] <= bus.c_pushA;
            pz[0] <= calc_f(bus.c_A, bus.c_B, bus.c_C);
            for (int i = 1; i < CALC_LAT; i++) begin
                pv[i] <= pv[i-1];
                pz[i] <= pz[i-1];
            end
        end
    end

    assign bus.c_pushZ = pv[CALC_LAT-1] | inj_pushZ;
    assign bus.c_Z     = inj_pushZ ? inj_z : pz[CALC_LAT-1];
    assign bus.c_stopA = stop_a;
    assign bus.c_stopB = 1'b0;
    assign bus.c_stopC = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // req0 (1,1,1)->7, req1 (2,0,0)->32, req2 (0,2,0)->8, req3 (0,0,3)->9
    task automatic load_ops();
        bus.req_A = {32'd0, 32'd0, 32'd2, 32'd1};
        bus.req_B = {32'd0, 32'd2, 32'd0, 32'd1};
        bus.req_C = {32'd3, 32'd0, 32'd0, 32'd1};
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.req_push = '0;
        bus.stopZ    = 1'b0;
        stop_a       = 1'b0;
        inj_pushZ    = 1'b0;
        inj_z        = '0;
        load_ops();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.stopZ    = 1'b0;
        stop_a       = 1'b0;
        inj_pushZ    = 1'b0;
        inj_z        = '0;
        load_ops();
        bus.req_push = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.req_stop !== 4'hF) begin
            n_err++; $display("FAIL reset_req_stop: got %h expected f", bus.req_stop);
        end
        n_vec++;
        if ({bus.c_pushA, bus.c_pushB, bus.c_pushC} !== 3'b000) begin
            n_err++; $display("FAIL reset_c_push: got %b expected 000", {bus.c_pushA, bus.c_pushB, bus.c_pushC});
        end
        n_vec++;
        if ({bus.c_A, bus.c_B, bus.c_C} !== 96'd0) begin
            n_err++; $display("FAIL reset_c_ops: got %h expected 0", {bus.c_A, bus.c_B, bus.c_C});
        end
        n_vec++;
        if ({bus.pushZ, bus.tagZ, bus.Z, bus.err} !== 36'd0) begin
            n_err++; $display("FAIL reset_outputs: got pushZ=%b tagZ=%0d Z=%0h err=%b expected all 0",
                              bus.pushZ, bus.tagZ, bus.Z, bus.err);
        end
        bus.req_push = '0;
        tick();
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        bus.req_push = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (bus.req_stop !== 4'b1110) begin
            n_err++; $display("FAIL single_grant: got %b expected 1110", bus.req_stop);
        end
        n_vec++;
        if ({bus.c_pushA, bus.c_A, bus.c_B, bus.c_C} !== {1'b1, 32'd1, 32'd1, 32'd1}) begin
            n_err++; $display("FAIL single_issue: got push=%b A=%0h B=%0h C=%0h expected 1/1/1/1",
                              bus.c_pushA, bus.c_A, bus.c_B, bus.c_C);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) bus.req_push = '0;
            @(negedge clk);
            n_vec++;
            if (c == 3) begin
                if ({bus.pushZ, bus.tagZ, bus.Z} !== {1'b1, 2'd0, 32'd7}) begin
                    n_err++; $display("FAIL single_result: got pushZ=%b tagZ=%0d Z=%0d expected 1/0/7",
                                      bus.pushZ, bus.tagZ, bus.Z);
                end
            end else if (bus.pushZ !== 1'b0) begin
                n_err++; $display("FAIL single_latency_c%0d: got pushZ=%b expected 0", c, bus.pushZ);
            end
        end
        $display("test_single done");
    endtask

    task automatic test_all4();
        int         grant_exp [5];
        res_entry_t res_exp [5];
        logic [3:0] exp_stop;
        grant_exp = '{0, 1, 2, 3, 0};
        res_exp[0] = '{tag: 2'd0, z: 32'd7};
        res_exp[1] = '{tag: 2'd1, z: 32'd32};
        res_exp[2] = '{tag: 2'd2, z: 32'd8};
        res_exp[3] = '{tag: 2'd3, z: 32'd9};
        res_exp[4] = '{tag: 2'd0, z: 32'd7};
        do_reset();
        bus.req_push = 4'hF;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            if (c == 5) bus.req_push = '0;
            @(negedge clk);
            if (c < 5) begin
                exp_stop = ~(4'b0001 << grant_exp[c]);
                n_vec++;
                if (bus.req_stop !== exp_stop) begin
                    n_err++; $display("FAIL all4_grant_c%0d: got %b expected %b", c, bus.req_stop, exp_stop);
                end
            end
            if (c >= 3) begin
                n_vec++;
                if ({bus.pushZ, bus.tagZ, bus.Z} !== {1'b1, res_exp[c-3].tag, res_exp[c-3].z}) begin
                    n_err++; $display("FAIL all4_result_c%0d: got pushZ=%b tagZ=%0d Z=%0d expected 1/%0d/%0d",
                                      c, bus.pushZ, bus.tagZ, bus.Z, res_exp[c-3].tag, res_exp[c-3].z);
                end
            end
        end
        $display("test_all4 done");
    endtask

    task automatic test_credit();
        int issued;
        do_reset();
        bus.stopZ    = 1'b1;
        bus.req_push = 4'b0001;
        issued       = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            if (bus.c_pushA === 1'b1) issued++;
        end
        n_vec++;
        if (issued !== 4) begin
            n_err++; $display("FAIL credit_issues: got %0d expected 4", issued);
        end
        n_vec++;
        if ({bus.req_stop, bus.pushZ, bus.tagZ, bus.Z} !== {4'hF, 1'b1, 2'd0, 32'd7}) begin
            n_err++; $display("FAIL credit_exhausted: got stop=%b pushZ=%b tagZ=%0d Z=%0d expected 1111/1/0/7",
                              bus.req_stop, bus.pushZ, bus.tagZ, bus.Z);
        end
        issued = 0;
        for (int c = 10; c < 16; c++) begin
            tick();
            bus.stopZ = (c == 10) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (bus.c_pushA === 1'b1) issued++;
        end
        n_vec++;
        if (issued !== 1) begin
            n_err++; $display("FAIL credit_one_pop: got %0d issues expected 1", issued);
        end
        n_vec++;
        if (bus.req_stop !== 4'hF) begin
            n_err++; $display("FAIL credit_refull: got %b expected 1111", bus.req_stop);
        end
        $display("test_credit done");
    endtask

    task automatic test_calc_stop();
        do_reset();
        stop_a       = 1'b1;
        bus.req_push = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            n_vec++;
            if ({bus.req_stop, bus.c_pushA, bus.c_pushB, bus.c_pushC} !== {4'hF, 3'b000}) begin
                n_err++; $display("FAIL calc_stop_c%0d: got stop=%b push=%b%b%b expected 1111/000",
                                  c, bus.req_stop, bus.c_pushA, bus.c_pushB, bus.c_pushC);
            end
        end
        tick();
        stop_a = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.req_stop, bus.c_pushA, bus.c_pushB, bus.c_pushC, bus.c_A, bus.c_B} !==
            {4'b1011, 3'b111, 32'd0, 32'd2}) begin
            n_err++; $display("FAIL calc_stop_release: got stop=%b push=%b%b%b A=%0d B=%0d expected 1011/111/0/2",
                              bus.req_stop, bus.c_pushA, bus.c_pushB, bus.c_pushC, bus.c_A, bus.c_B);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) bus.req_push = '0;
            @(negedge clk);
        end
        n_vec++;
        if ({bus.pushZ, bus.tagZ, bus.Z} !== {1'b1, 2'd2, 32'd8}) begin
            n_err++; $display("FAIL calc_stop_result: got pushZ=%b tagZ=%0d Z=%0d expected 1/2/8",
                              bus.pushZ, bus.tagZ, bus.Z);
        end
        $display("test_calc_stop done");
    endtask

    task automatic test_err();
        do_reset();
        @(negedge clk);
        n_vec++;
        if (bus.err !== 1'b0) begin
            n_err++; $display("FAIL err_initial: got %b expected 0", bus.err);
        end
        tick();
        inj_pushZ = 1'b1;
        inj_z     = 32'hDEAD_BEEF;
        tick();
        inj_pushZ = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.err, bus.pushZ} !== 2'b10) begin
            n_err++; $display("FAIL err_set: got err=%b pushZ=%b expected 1/0", bus.err, bus.pushZ);
        end
        repeat (3) tick();
        @(negedge clk);
        n_vec++;
        if ({bus.err, bus.pushZ} !== 2'b10) begin
            n_err++; $display("FAIL err_sticky: got err=%b pushZ=%b expected 1/0", bus.err, bus.pushZ);
        end
        tick();
        bus.req_push = 4'b0010;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) bus.req_push = '0;
            @(negedge clk);
        end
        n_vec++;
        if ({bus.err, bus.pushZ, bus.tagZ, bus.Z} !== {1'b1, 1'b1, 2'd1, 32'd32}) begin
            n_err++; $display("FAIL err_after_result: got err=%b pushZ=%b tagZ=%0d Z=%0d expected 1/1/1/32",
                              bus.err, bus.pushZ, bus.tagZ, bus.Z);
        end
        $display("test_err done");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.stopZ    = 1'b1;
        bus.req_push = 4'b0111;
        repeat (3) tick();
        bus.req_push = '0;
        @(negedge clk);
        n_vec++;
        if ({bus.pushZ, bus.tagZ, bus.Z} !== {1'b1, 2'd0, 32'd7}) begin
            n_err++; $display("FAIL midflight_pre: got pushZ=%b tagZ=%0d Z=%0d expected 1/0/7",
                              bus.pushZ, bus.tagZ, bus.Z);
        end
        #1 rst_n = 1'b0;
        #2;
        n_vec++;
        if ({bus.req_stop, bus.c_pushA, bus.pushZ, bus.tagZ, bus.Z, bus.err} !==
            {4'hF, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0}) begin
            n_err++; $display("FAIL midflight_reset: got stop=%b c_push=%b pushZ=%b tagZ=%0d Z=%0h err=%b expected 1111/0/0/0/0/0",
                              bus.req_stop, bus.c_pushA, bus.pushZ, bus.tagZ, bus.Z, bus.err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.stopZ = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            n_vec++;
            if (bus.pushZ !== 1'b0) begin
                n_err++; $display("FAIL midflight_stale_c%0d: got pushZ=%b tagZ=%0d expected pushZ 0",
                                  c, bus.pushZ, bus.tagZ);
            end
        end
        tick();
        bus.req_push = 4'b1000;
        @(negedge clk);
        n_vec++;
        if (bus.req_stop !== 4'b0111) begin
            n_err++; $display("FAIL midflight_new_grant: got %b expected 0111", bus.req_stop);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) bus.req_push = '0;
            @(negedge clk);
            n_vec++;
            if (c < 3 && bus.pushZ !== 1'b0) begin
                n_err++; $display("FAIL midflight_early_c%0d: got pushZ=%b expected 0", c, bus.pushZ);
            end else if (c == 3 && {bus.pushZ, bus.tagZ, bus.Z} !== {1'b1, 2'd3, 32'd9}) begin
                n_err++; $display("FAIL midflight_first_result: got pushZ=%b tagZ=%0d Z=%0d expected 1/3/9",
                                  bus.pushZ, bus.tagZ, bus.Z);
            end
        end
        $display("test_reset_midflight done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.req_push = '0;
        bus.stopZ    = 1'b0;
        stop_a       = 1'b0;
        inj_pushZ    = 1'b0;
        inj_z        = '0;
        load_ops();
        test_reset();
        test_single();
        test_all4();
        test_credit();
        test_calc_stop();
        test_err();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
